// File: rtl/jt51_pkg.sv
// Shared definitions for the JT51 interpolation scheduler.
//   W_DEF   : default sample width
//   clog2   : bit width needed to count 0..value-1 (never below 1)
//   quarter : FIR4 strobe spacing, (DIV+1)/4 clocks
//   div_ok  : true when a slot of DIV+1 clocks splits into four equal parts
package jt51_pkg;

    localparam int W_DEF = 16;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int quarter(input int div);
        return (div + 1) / 4;
    endfunction

    function automatic bit div_ok(input int div);
        return ((div + 1) % 4) == 0;
    endfunction

endpackage

// File: rtl/jt51_hold_reg.sv
// One-entry valid/ready holding register with a consume port.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   valid, ready    : producer handshake, a word moves on valid && ready
//   in_l, in_r      : offered left/right sample
//   consume         : slot event taking the held word this cycle
//   clr_flags       : clears the sticky flags (a same-cycle set wins)
//   data_l, data_r  : register contents; after a consume they keep the
//                     last consumed word until the next load
//   underrun        : sticky, consume seen while empty
//   overrun         : sticky, offer seen while full and not being consumed
// Handshake: ready is !full and depends only on registered state, so the
// producer may hold valid high combinationally against it without a loop.
module jt51_hold_reg
    import jt51_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    output logic         ready,
    input  logic [W-1:0] in_l,
    input  logic [W-1:0] in_r,
    input  logic         consume,
    input  logic         clr_flags,
    output logic [W-1:0] data_l,
    output logic [W-1:0] data_r,
    output logic         underrun,
    output logic         overrun
);

    logic full;
    logic accept;

    assign ready  = !full;
    assign accept = valid && !full;

    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= 1'b0;
            data_l   <= '0;
            data_r   <= '0;
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            // A load into an empty register beats a same-cycle consume: the
            // consumer sees the old contents and the new word stays held.
            if (accept) begin
                full   <= 1'b1;
                data_l <= in_l;
                data_r <= in_r;
            end else if (consume) begin
                full <= 1'b0;
            end

            if (consume && !full) underrun <= 1'b1;
            else if (clr_flags)   underrun <= 1'b0;

            // An offer that meets a draining register is silently refused;
            // ready reopens on the next cycle.
            if (valid && full && !consume) overrun <= 1'b1;
            else if (clr_flags)            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/jt51_interpol_sched.sv
// Sequencer/arbiter in front of the JT51 FIR8 -> FIR4 interpolation chain.
// Two sources share the FIR8 input: src A (FM core) feeds phase 0 and src B
// (PCM/ADPCM) feeds phase B_PHASE; every other phase is zero-stuffed.
// Ports:
//   clk, rst, en               : clock, sync active-high reset, run enable
//   a_valid/a_ready/a_l/a_r    : src A handshake and data
//   b_valid/b_ready/b_l/b_r    : src B handshake and data
//   fir_sample, fir_l, fir_r   : FIR8 strobe (once per slot) and held data
//   fir4_sample                : FIR4 strobe (four per slot)
//   phase                      : current slot phase 0..PHASES-1
//   a/b_underrun, a/b_overrun  : sticky error flags
//   clr_flags                  : clears all sticky flags
module jt51_interpol_sched
    import jt51_pkg::*;
#(
    parameter int DIV     = 111,
    parameter int PHASES  = 8,
    parameter int B_PHASE = 3,
    parameter int W       = W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [W-1:0]              a_l,
    input  logic [W-1:0]              a_r,
    input  logic                      b_valid,
    output logic                      b_ready,
    input  logic [W-1:0]              b_l,
    input  logic [W-1:0]              b_r,
    output logic                      fir_sample,
    output logic [W-1:0]              fir_l,
    output logic [W-1:0]              fir_r,
    output logic                      fir4_sample,
    output logic [clog2(PHASES)-1:0]  phase,
    output logic                      a_underrun,
    output logic                      b_underrun,
    output logic                      a_overrun,
    output logic                      b_overrun,
    input  logic                      clr_flags
);

    localparam int PW = clog2(PHASES);
    localparam int CW = clog2(DIV + 1);
    localparam int Q  = quarter(DIV);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV);
    localparam logic [CW-1:0] CNT_Q1   = CW'(Q);
    localparam logic [CW-1:0] CNT_Q2   = CW'(2 * Q);
    localparam logic [CW-1:0] CNT_Q3   = CW'(3 * Q);
    localparam logic [PW-1:0] PH_LAST  = PW'(PHASES - 1);
    localparam logic [PW-1:0] PH_B     = PW'(B_PHASE);

    if (!div_ok(DIV)) begin : g_div_check
        $error("jt51_interpol_sched: DIV+1 must be a multiple of 4");
    end

    logic [CW-1:0] cnt;
    logic          slot;
    logic          q_tick;
    logic          consume_a;
    logic          consume_b;
    logic [W-1:0]  a_data_l, a_data_r;
    logic [W-1:0]  b_data_l, b_data_r;
    logic [W-1:0]  sel_l, sel_r;

    assign slot      = en && (cnt == CNT_LAST);
    assign q_tick    = en && ((cnt == '0) || (cnt == CNT_Q1) ||
                              (cnt == CNT_Q2) || (cnt == CNT_Q3));
    assign consume_a = slot && (phase == '0);
    assign consume_b = slot && (phase == PH_B);

    jt51_hold_reg #(.W(W)) u_hold_a (
        .clk       (clk),
        .rst       (rst),
        .valid     (a_valid),
        .ready     (a_ready),
        .in_l      (a_l),
        .in_r      (a_r),
        .consume   (consume_a),
        .clr_flags (clr_flags),
        .data_l    (a_data_l),
        .data_r    (a_data_r),
        .underrun  (a_underrun),
        .overrun   (a_overrun)
    );

    jt51_hold_reg #(.W(W)) u_hold_b (
        .clk       (clk),
        .rst       (rst),
        .valid     (b_valid),
        .ready     (b_ready),
        .in_l      (b_l),
        .in_r      (b_r),
        .consume   (consume_b),
        .clr_flags (clr_flags),
        .data_l    (b_data_l),
        .data_r    (b_data_r),
        .underrun  (b_underrun),
        .overrun   (b_overrun)
    );

    // Src A repeats its last consumed word when empty (the hold register
    // keeps it); src B falls back to silence. b_ready low means B is full.
    always_comb begin
        sel_l = '0;
        sel_r = '0;
        if (phase == '0) begin
            sel_l = a_data_l;
            sel_r = a_data_r;
        end else if (phase == PH_B && !b_ready) begin
            sel_l = b_data_l;
            sel_r = b_data_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            phase       <= '0;
            fir_sample  <= 1'b0;
            fir4_sample <= 1'b0;
            fir_l       <= '0;
            fir_r       <= '0;
        end else begin
            fir_sample  <= slot;
            fir4_sample <= q_tick;
            if (en) begin
                if (cnt == CNT_LAST) begin
                    cnt   <= '0;
                    phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (slot) begin
                fir_l <= sel_l;
                fir_r <= sel_r;
            end
        end
    end

endmodule

// File: tb/tb_jt51_interpol_sched.sv
// Self-checking bench for jt51_interpol_sched. A reference model counts
// enabled clocks since reset and derives slot position and phase from that
// count by division; each source is modelled as a queue of at most one word.
// Every clock all outputs are compared with the model, and directed steps
// add explicit checks for latencies and flag behaviour.
module tb_jt51_interpol_sched;

    localparam int DIV     = 111;
    localparam int PHASES  = 8;
    localparam int B_PHASE = 3;
    localparam int W       = 16;
    localparam int SLOT    = DIV + 1;
    localparam int Q       = SLOT / 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, en, a_valid, b_valid, clr_flags;
    logic [W-1:0] a_l, a_r, b_l, b_r;
    logic         a_ready, b_ready, fir_sample, fir4_sample;
    logic [W-1:0] fir_l, fir_r;
    logic [2:0]   phase;
    logic         a_underrun, b_underrun, a_overrun, b_overrun;

    jt51_interpol_sched #(
        .DIV(DIV), .PHASES(PHASES), .B_PHASE(B_PHASE), .W(W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_l         (a_l),
        .a_r         (a_r),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_l         (b_l),
        .b_r         (b_r),
        .fir_sample  (fir_sample),
        .fir_l       (fir_l),
        .fir_r       (fir_r),
        .fir4_sample (fir4_sample),
        .phase       (phase),
        .a_underrun  (a_underrun),
        .b_underrun  (b_underrun),
        .a_overrun   (a_overrun),
        .b_overrun   (b_overrun),
        .clr_flags   (clr_flags)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int             m_ticks;
    logic [2*W-1:0] a_q[$];
    logic [2*W-1:0] b_q[$];
    logic [W-1:0]   m_a_last_l, m_a_last_r, m_fir_l, m_fir_r;
    bit             m_fs, m_f4, m_a_un, m_b_un, m_a_ov, m_b_ov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic int m_phase();
        return (m_ticks / SLOT) % PHASES;
    endfunction

    // Phase of the slot whose strobe has just been issued
    function automatic int strobe_phase();
        return ((m_ticks / SLOT) + PHASES - 1) % PHASES;
    endfunction

    task automatic model_reset();
        m_ticks = 0;
        a_q.delete();
        b_q.delete();
        m_a_last_l = '0; m_a_last_r = '0;
        m_fir_l = '0; m_fir_r = '0;
        m_fs = 0; m_f4 = 0;
        m_a_un = 0; m_b_un = 0; m_a_ov = 0; m_b_ov = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int pos, ph;
        bit a_empty, b_empty, a_cons, b_cons, a_un, b_un, a_ov, b_ov;
        logic [2*W-1:0] word;
        if (rst) begin
            model_reset();
            return;
        end
        a_empty = (a_q.size() == 0);
        b_empty = (b_q.size() == 0);
        a_cons = 0; b_cons = 0; a_un = 0; b_un = 0; a_ov = 0; b_ov = 0;
        m_fs = 0;
        m_f4 = 0;
        if (en) begin
            pos = m_ticks % SLOT;
            ph  = (m_ticks / SLOT) % PHASES;
            m_f4 = (pos % Q) == 0;
            if (pos == DIV) begin
                m_fs = 1;
                if (ph == 0) begin
                    if (!a_empty) begin
                        word = a_q.pop_front();
                        {m_a_last_l, m_a_last_r} = word;
                        a_cons = 1;
                    end else begin
                        a_un = 1;
                    end
                    m_fir_l = m_a_last_l;
                    m_fir_r = m_a_last_r;
                end else if (ph == B_PHASE) begin
                    if (!b_empty) begin
                        word = b_q.pop_front();
                        {m_fir_l, m_fir_r} = word;
                        b_cons = 1;
                    end else begin
                        m_fir_l = '0; m_fir_r = '0;
                        b_un = 1;
                    end
                end else begin
                    m_fir_l = '0; m_fir_r = '0;
                end
            end
            m_ticks++;
        end
        if (a_valid) begin
            if (a_empty) a_q.push_back({a_l, a_r});
            else if (!a_cons) a_ov = 1;
        end
        if (b_valid) begin
            if (b_empty) b_q.push_back({b_l, b_r});
            else if (!b_cons) b_ov = 1;
        end
        m_a_un = a_un ? 1'b1 : (clr_flags ? 1'b0 : m_a_un);
        m_b_un = b_un ? 1'b1 : (clr_flags ? 1'b0 : m_b_un);
        m_a_ov = a_ov ? 1'b1 : (clr_flags ? 1'b0 : m_a_ov);
        m_b_ov = b_ov ? 1'b1 : (clr_flags ? 1'b0 : m_b_ov);
    endtask

    task automatic check_all();
        chk("fir_sample", fir_sample, m_fs);
        chk("fir4_sample", fir4_sample, m_f4);
        chk("fir_l", fir_l, m_fir_l);
        chk("fir_r", fir_r, m_fir_r);
        chk("phase", phase, m_phase());
        chk("a_ready", a_ready, a_q.size() == 0);
        chk("b_ready", b_ready, b_q.size() == 0);
        chk("a_underrun", a_underrun, m_a_un);
        chk("b_underrun", b_underrun, m_b_un);
        chk("a_overrun", a_overrun, m_a_ov);
        chk("b_overrun", b_overrun, m_b_ov);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_fir(input int max_cyc, output int cyc);
        cyc = 0;
        while (cyc < max_cyc) begin
            step();
            cyc++;
            if (fir_sample) break;
        end
    endtask

    task automatic run_until_pos(input int p);
        for (int i = 0; i < SLOT + 1 && (m_ticks % SLOT) != p; i++) step();
    endtask

    task automatic offer_a(input logic [W-1:0] l, input logic [W-1:0] r);
        a_valid = 1'b1; a_l = l; a_r = r;
        step();
        a_valid = 1'b0;
    endtask

    task automatic offer_b(input logic [W-1:0] l, input logic [W-1:0] r);
        b_valid = 1'b1; b_l = l; b_r = r;
        step();
        b_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
    endtask

    initial begin
        int cyc;
        rst = 1'b1; en = 1'b0; a_valid = 1'b0; b_valid = 1'b0; clr_flags = 1'b0;
        a_l = '0; a_r = '0; b_l = '0; b_r = '0;
        model_reset();

        // Reset state
        run(2);
        chk("reset_a_ready", a_ready, 1);
        chk("reset_b_ready", b_ready, 1);
        chk("reset_fir_l", fir_l, 0);
        chk("reset_phase", phase, 0);

        // Idle run: strobe timing and A underrun on the first phase-0 slot
        rst = 1'b0; en = 1'b1;
        step();
        chk("fir4_first", fir4_sample, 1);
        run_until_fir(SLOT + 4, cyc);
        chk("first_fir_latency", cyc + 1, SLOT);
        chk("idle_fir_l", fir_l, 0);
        chk("idle_a_underrun", a_underrun, 1);
        run(7 * SLOT);

        // Single src A word, then repeat of the last value with underrun
        pulse_clr();
        chk("clr_underrun", a_underrun, 0);
        offer_a(16'h1234, 16'hEDCC);
        run_until_fir(SLOT, cyc);
        chk("a_phase0_l", fir_l, 16'h1234);
        chk("a_phase0_r", fir_r, 16'hEDCC);
        for (int k = 1; k < PHASES; k++) begin
            run_until_fir(SLOT + 2, cyc);
            chk("strobe_interval", cyc, SLOT);
            chk("zero_stuff_l", fir_l, 0);
            chk("zero_stuff_r", fir_r, 0);
        end
        run_until_fir(SLOT + 2, cyc);
        chk("a_repeat_l", fir_l, 16'h1234);
        chk("a_repeat_r", fir_r, 16'hEDCC);
        chk("a_repeat_underrun", a_underrun, 1);

        // Src B once per period, one offer omitted
        for (int p = 0; p < 3; p++) begin
            pulse_clr();
            if (p != 1) offer_b(16'h7FFF, 16'h8000);
            for (int k = 0; k < PHASES; k++) begin
                run_until_fir(SLOT + 2, cyc);
                if (strobe_phase() == B_PHASE) begin
                    chk("b_phase_l", fir_l, (p != 1) ? 16'h7FFF : 16'h0000);
                    chk("b_phase_r", fir_r, (p != 1) ? 16'h8000 : 16'h0000);
                    chk("b_underrun", b_underrun, p == 1);
                end
            end
        end

        // Two src A offers in one period
        offer_a(16'h1111, 16'h2222);
        run(5);
        chk("a_ready_full", a_ready, 0);
        offer_a(16'h3333, 16'h4444);
        chk("a_overrun_set", a_overrun, 1);
        for (int k = 0; k < PHASES; k++) begin
            run_until_fir(SLOT + 2, cyc);
            if (strobe_phase() == 0) begin
                chk("a_first_kept_l", fir_l, 16'h1111);
                chk("a_first_kept_r", fir_r, 16'h2222);
                break;
            end
        end
        pulse_clr();
        chk("a_overrun_clr", a_overrun, 0);
        offer_a(16'h5555, 16'h6666);
        a_valid = 1'b1; a_l = 16'h7777; a_r = 16'h8888; clr_flags = 1'b1;
        step();
        a_valid = 1'b0; clr_flags = 1'b0;
        chk("overrun_beats_clr", a_overrun, 1);

        // Enable drop at cnt=50 for 200 clocks, B loaded meanwhile
        run_until_pos(50);
        en = 1'b0;
        for (int i = 0; i < 200; i++) begin
            b_valid = (i == 10);
            b_l = 16'h0BBB; b_r = 16'h0CCC;
            step();
            chk("en_low_fir", fir_sample, 0);
            chk("en_low_fir4", fir4_sample, 0);
        end
        b_valid = 1'b0;
        chk("en_low_b_loaded", b_ready, 0);
        en = 1'b1;
        run_until_fir(SLOT, cyc);
        chk("resume_latency", cyc, 62);

        // Reset at cnt=70 with A full
        run_until_pos(69);
        offer_a(16'h0A0A, 16'h0B0B);
        chk("a_full_before_rst", a_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_a_ready", a_ready, 1);
        chk("rst_fir_l", fir_l, 0);
        chk("rst_phase", phase, 0);
        chk("rst_a_overrun", a_overrun, 0);
        run_until_fir(SLOT + 4, cyc);
        chk("rst_fir_latency", cyc, SLOT);
        chk("rst_fir_data", fir_l, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            a_valid   = ($urandom_range(0, 99) < 3);
            b_valid   = ($urandom_range(0, 99) < 2);
            a_l       = W'($urandom); a_r = W'($urandom);
            b_l       = W'($urandom); b_r = W'($urandom);
            en        = ($urandom_range(0, 19) != 0);
            clr_flags = ($urandom_range(0, 199) == 0);
            rst       = ($urandom_range(0, 1499) == 0);
            step();
        end
        rst = 1'b0; en = 1'b0; a_valid = 1'b0; b_valid = 1'b0; clr_flags = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
